menu_screen_ctrl: RTL
=====================

// Module: menu_screen_ctrl
// PURPOSE
//  Screen sequencer for the full-screen image ROM/palette renderers. Decodes keyboard presses,
//  walks the title -> menu -> game -> game-over flow, and picks which full-screen image is shown.
//  Drives a palette fade level for frame-synchronous fade-out/fade-in between screens.
//  Sits between the keyboard keycode interface and the pixel output mux in the top level.
// PARAMETERS
//  NUM_ITEMS    3  number of menu entries; item 0 = START GAME, item NUM_ITEMS-1 = BACK TO TITLE
//  FADE_FRAMES  2  frame_sync pulses per fade step (>=1)
// PORTS
//  vga_clk     in   1   pixel clock; the only clock
//  reset_n     in   1   asynchronous, active-low reset
//  frame_sync  in   1   one-cycle pulse at start of vertical blank
//  key_valid   in   1   high while a key is held; level signal
//  keycode     in   8   HID keycode, valid while key_valid=1
//  game_over   in   1   one-cycle pulse from game logic
//  screen_sel  out  2   image select: 0 TITLE, 1 MENU, 2 GAME, 3 OVER
//  fade_level  out  4   palette scale 0..15 (15 = full brightness)
//  cursor_idx  out  $clog2(NUM_ITEMS)  highlighted menu item
//  game_start  out  1   one-cycle pulse when GAME is entered
//  in_game     out  1   high while state == GAME
// BEHAVIOUR
//  Reset (async, any time, including mid-fade): state=TITLE, screen_sel=0, fade_level=15,
//   cursor_idx=0, game_start=0, in_game=0, fade counter=0, target=TITLE.
//  Key press: one rising edge of key_valid (registered previous value) = exactly one event.
//   A held key is never repeated. Keycodes: ENTER=8'h28, UP=8'h52, DOWN=8'h51; others ignored.
//  States:
//   TITLE: ENTER -> MENU; cursor_idx cleared to 0.
//   MENU: UP dec cursor, wraps 0 -> NUM_ITEMS-1. DOWN inc, wraps NUM_ITEMS-1 -> 0.
//    ENTER: target = GAME if cursor==0, TITLE if cursor==NUM_ITEMS-1, else stay in MENU.
//    On GAME/TITLE target -> FADE_OUT.
//   FADE_OUT: on every FADE_FRAMES-th frame_sync, fade_level-=1. When fade_level reaches 0,
//    screen_sel <= target on that same cycle -> FADE_IN.
//   FADE_IN: on every FADE_FRAMES-th frame_sync, fade_level+=1. On reaching 15 -> target state.
//    game_start pulses for 1 cycle on entry if target==GAME.
//   GAME: game_over pulse -> target=OVER, FADE_OUT. Key events ignored.
//   OVER: ENTER -> TITLE directly, no fade.
//  screen_sel outside fades: updated only on a frame_sync cycle to the current state's image,
//   so images never tear mid-frame.
//  Ignored inputs: key events during FADE_OUT/FADE_IN; game_over outside GAME.
//  Fade counter clears on entry to FADE_OUT and FADE_IN.
//  Key event and frame_sync in the same cycle: state updates now. screen_sel takes the new
//   value at the next frame_sync.
//  fade_level saturates at 0 and 15, never wraps. in_game is registered from state, 1-cycle lag.
// CONFIGURATION
//  MENU_FADE_EN defined: fades as above.
//  MENU_FADE_EN undefined: FADE_OUT/FADE_IN are bypassed. The transition goes straight to the
//   target at the next frame_sync, with screen_sel updated in that same cycle.
//   fade_level is tied to 15 and the fade counter is not instantiated. game_start timing is unchanged.
// STRUCTURE
//  Package menu_pkg: state_e (TITLE, MENU, FADE_OUT, FADE_IN, GAME, OVER), screen_e (2-bit),
//   KEY_ENTER/KEY_UP/KEY_DOWN localparams, FADE_MAX=4'd15.
//  Sub-module menu_fade_timer: counts frame_sync pulses and emits a one-cycle step strobe
//   every FADE_FRAMES pulses. It has a synchronous clear and the same vga_clk/reset_n.
// TESTING
//  1 Reset, then ENTER press -> state MENU. screen_sel=1 after next frame_sync. cursor_idx=0.
//  2 MENU: UP once -> cursor=2. DOWN x2 -> cursor=1. ENTER held 100 cycles -> one event,
//    state stays MENU.
//  3 MENU cursor=0, ENTER, FADE_FRAMES=2 -> fade 15->0 over 30 frame_syncs. screen_sel=2 at 0.
//    Then 0->15 over 30 more. game_start pulses once, in_game=1.
//  4 GAME: game_over -> fade to OVER, screen_sel=3. ENTER -> TITLE, screen_sel=0 at next
//    frame_sync, fade stays 15.
//  5 reset_n low mid-FADE_OUT at fade_level=7 -> all outputs at reset values immediately.
//    Keys pressed during a fade are ignored.
//  6 MENU_FADE_EN undefined: MENU ENTER cursor=0 -> GAME at next frame_sync, fade_level
//    constant 15, one game_start pulse.

Source files
------------

// File: rtl/menu_screen_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : menu_pkg
// Description : Shared types and constants for the menu/screen sequencer:
//               FSM state encoding, image select encoding, keyboard
//               keycodes and the full-brightness fade level.
// Revision    : 1.0 - initial release
// ============================================================================
package menu_pkg;

    typedef enum logic [2:0] {
        TITLE    = 3'd0,
        MENU     = 3'd1,
        FADE_OUT = 3'd2,
        FADE_IN  = 3'd3,
        GAME     = 3'd4,
        OVER     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SCR_TITLE = 2'd0,
        SCR_MENU  = 2'd1,
        SCR_GAME  = 2'd2,
        SCR_OVER  = 2'd3
    } screen_e;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [3:0] FADE_MAX  = 4'd15;

    // Image shown for a steady state; fade states have no image of their own.
    function automatic screen_e screen_of(input state_e s);
        case (s)
            MENU:    return SCR_MENU;
            GAME:    return SCR_GAME;
            OVER:    return SCR_OVER;
            default: return SCR_TITLE;
        endcase
    endfunction

endpackage : menu_pkg
`default_nettype wire

// File: rtl/menu_screen_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : menu_screen_ctrl_if
// Description : Keyboard / game-logic inputs and screen-control outputs of
//               the menu sequencer. master = surrounding top level,
//               slave = menu_screen_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface menu_screen_ctrl_if #(
    parameter int NUM_ITEMS = 3
) ();
    localparam int CUR_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    logic             frame_sync;
    logic             key_valid;
    logic [7:0]       keycode;
    logic             game_over;
    logic [1:0]       screen_sel;
    logic [3:0]       fade_level;
    logic [CUR_W-1:0] cursor_idx;
    logic             game_start;
    logic             in_game;

    modport master (
        output frame_sync, key_valid, keycode, game_over,
        input  screen_sel, fade_level, cursor_idx, game_start, in_game
    );

    modport slave (
        input  frame_sync, key_valid, keycode, game_over,
        output screen_sel, fade_level, cursor_idx, game_start, in_game
    );
endinterface : menu_screen_ctrl_if
`default_nettype wire

// File: rtl/menu_screen_ctrl_fade_timer.sv
`default_nettype none
// ============================================================================
// Module      : menu_fade_timer
// Description : Counts frame_sync pulses and emits a one-cycle step strobe on
//               every FADE_FRAMES-th pulse. Synchronous clear restarts the
//               count (a frame_sync in the clear cycle is not counted).
//               Only instantiated when MENU_FADE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module menu_fade_timer #(
    parameter int FADE_FRAMES = 2
) (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic clear,
    input  logic frame_sync,
    output logic step
);
    localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

    logic [CNT_W-1:0] count;

    assign step = frame_sync & ~clear & (count == CNT_LAST);

    // Frame pulse counter, wrapping after FADE_FRAMES pulses.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (frame_sync) begin
            count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
        end
    end
endmodule : menu_fade_timer
`default_nettype wire

// File: rtl/menu_screen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : menu_screen_ctrl
// Description : Screen sequencer: decodes key presses, walks the
//               title -> menu -> game -> game-over flow, selects the
//               full-screen image and drives the palette fade level.
//               Build option MENU_FADE_EN: when defined, screen changes fade
//               out/in one level per FADE_FRAMES frames; when undefined the
//               change happens at the next frame_sync and fade_level is 15.
// Revision    : 1.0 - initial release
// ============================================================================
module menu_screen_ctrl
    import menu_pkg::*;
#(
    parameter int NUM_ITEMS   = 3,
    parameter int FADE_FRAMES = 2
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    menu_screen_ctrl_if.slave bus
);
    localparam int CUR_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam logic [CUR_W-1:0] LAST_ITEM = CUR_W'(NUM_ITEMS - 1);

    state_e           state, state_next;
    state_e           target, target_next;
    logic [1:0]       screen_sel, screen_next;
    logic [CUR_W-1:0] cursor, cursor_next;
    logic             key_prev;
    logic             game_start, game_start_next;
    logic             in_game;
    logic [3:0]       fade_level;
    logic             key_evt, key_enter, key_up, key_down;

    // A key event is the rising edge of key_valid; holding never repeats.
    assign key_evt   = bus.key_valid & ~key_prev;
    assign key_enter = key_evt & (bus.keycode == KEY_ENTER);
    assign key_up    = key_evt & (bus.keycode == KEY_UP);
    assign key_down  = key_evt & (bus.keycode == KEY_DOWN);

`ifdef MENU_FADE_EN
    logic       fade_step;
    logic       fade_clear;
    logic [3:0] fade_next;

    menu_fade_timer #(
        .FADE_FRAMES (FADE_FRAMES)
    ) u_fade_timer (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .clear      (fade_clear),
        .frame_sync (bus.frame_sync),
        .step       (fade_step)
    );

    // Palette fade level register.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            fade_level <= FADE_MAX;
        end else begin
            fade_level <= fade_next;
        end
    end
`else
    assign fade_level = FADE_MAX;
`endif

    // State and output registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= TITLE;
            target     <= TITLE;
            screen_sel <= SCR_TITLE;
            cursor     <= '0;
            key_prev   <= 1'b0;
            game_start <= 1'b0;
            in_game    <= 1'b0;
        end else begin
            state      <= state_next;
            target     <= target_next;
            screen_sel <= screen_next;
            cursor     <= cursor_next;
            key_prev   <= bus.key_valid;
            game_start <= game_start_next;
            in_game    <= (state == GAME);
        end
    end

    // Next-state, cursor, image select and fade decisions.
    always_comb begin
        state_next  = state;
        target_next = target;
        screen_next = screen_sel;
        cursor_next = cursor;
`ifdef MENU_FADE_EN
        fade_next   = fade_level;
        fade_clear  = 1'b0;
`endif
        case (state)
            TITLE: begin
                if (key_enter) begin
                    state_next  = MENU;
                    cursor_next = '0;
                end
            end
            MENU: begin
                if (key_up) begin
                    cursor_next = (cursor == '0) ? LAST_ITEM : cursor - CUR_W'(1);
                end else if (key_down) begin
                    cursor_next = (cursor == LAST_ITEM) ? '0 : cursor + CUR_W'(1);
                end else if (key_enter) begin
                    if (cursor == '0) begin
                        target_next = GAME;
                        state_next  = FADE_OUT;
                    end else if (cursor == LAST_ITEM) begin
                        target_next = TITLE;
                        state_next  = FADE_OUT;
                    end
                end
            end
            GAME: begin
                if (bus.game_over) begin
                    target_next = OVER;
                    state_next  = FADE_OUT;
                end
            end
            OVER: begin
                if (key_enter) begin
                    state_next = TITLE;
                end
            end
            FADE_OUT: begin
`ifdef MENU_FADE_EN
                if (fade_step) begin
                    if (fade_level != 4'd0) begin
                        fade_next = fade_level - 4'd1;
                    end
                    // Swap the image while the screen is fully dark.
                    if (fade_level <= 4'd1) begin
                        screen_next = screen_of(target);
                        state_next  = FADE_IN;
                    end
                end
`else
                // Without fades this state only waits for the frame boundary.
                if (bus.frame_sync) begin
                    screen_next = screen_of(target);
                    state_next  = target;
                end
`endif
            end
            FADE_IN: begin
`ifdef MENU_FADE_EN
                if (fade_step) begin
                    if (fade_level != FADE_MAX) begin
                        fade_next = fade_level + 4'd1;
                    end
                    if (fade_level >= FADE_MAX - 4'd1) begin
                        state_next = target;
                    end
                end
`else
                state_next = target;
`endif
            end
            default: begin
                state_next = TITLE;
            end
        endcase

        // Steady screens refresh the image only at a frame boundary so a
        // change never tears mid-frame.
        if (bus.frame_sync && (state == TITLE || state == MENU ||
                               state == GAME  || state == OVER)) begin
            screen_next = screen_of(state);
        end

        game_start_next = (state_next == GAME) && (state != GAME);
`ifdef MENU_FADE_EN
        fade_clear = (state_next != state) &&
                     (state_next == FADE_OUT || state_next == FADE_IN);
`endif
    end

    assign bus.screen_sel = screen_sel;
    assign bus.fade_level = fade_level;
    assign bus.cursor_idx = cursor;
    assign bus.game_start = game_start;
    assign bus.in_game    = in_game;

endmodule : menu_screen_ctrl
`default_nettype wire
